clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Programmable, glitch-free integer clock divider with registered output, period-boundary ratio updates, an enable/hold control and single-cycle edge strobes. It is the general-purpose replacement for the fixed divide-by-8 clock generator. It supplies slow sample/stage clocks and enable strobes to the DCT datapath and the EEG compression pipeline. All logic runs on a single reference clock; `clk_out` is a registered signal and never glitches.

## Interface
- `CNT_W`, 8: width of the divide-ratio and phase counters; ratios up to 2^CNT_W-1.
- `DEFAULT_DIV`, 8: active ratio loaded at reset; must be in 2..2^CNT_W-1.
- `clk` input 1: reference clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous and active-high; one clock.
- `en` input 1: 1 = divider runs; 0 = counter and `clk_out` hold their current values.
- `div_load` input 1: one-cycle strobe; captures `div_ratio` into the shadow register.
- `div_ratio` input CNT_W: requested ratio N, sampled only when `div_load`=1.
- `duty_high` input CNT_W: high-phase length in reference cycles. Present only with `CLK_DIV_DUTY_PROG_EN`.
- `clk_out` output 1: divided clock.
- `tick_rise` output 1: one-cycle pulse, high in the cycle where `clk_out` goes 0→1.
- `tick_fall` output 1: one-cycle pulse, high in the cycle where `clk_out` goes 1→0.
- `pending` output 1: 1 while a loaded ratio waits for the next period boundary.
- `active_div` output CNT_W: ratio currently in effect.

## Operation
- **State:** phase counter `cnt` (0..N-1), active ratio N, shadow ratio, pending flag.
- **Sanitising:** a requested value of 0 or 1 is clamped to 2 when captured, so `active_div` is never below 2.
- **Counter, with `en`=1:**
  - `cnt` increments each cycle.
  - At `cnt`==N-1 (the period boundary), `cnt` wraps to 0.
  - At the boundary, if `pending`=1, N takes the shadow value and `pending` clears in the same cycle.
- **High phase H:**
  - Without the macro, H = ceil(N/2); odd N gives one extra high cycle.
  - Next `clk_out` = (`cnt` < H).
- **Edge strobes:** registered alongside `clk_out`.
  - `tick_rise` = next `clk_out`=1 while current `clk_out`=0.
  - `tick_fall` = the inverse transition.
- **Load handling:**
  - `div_load` sets `pending`=1 and overwrites the shadow value.
  - A second load before the boundary replaces the first; the last value wins.
  - A load in the boundary cycle itself is not applied at that boundary. It is applied at the following boundary.
- **Enable:**
  - `en`=0 freezes `cnt`, `clk_out` and `pending`, and holds both strobes at 0.
  - Loads are still captured while `en`=0.
  - When `en` returns to 1, counting resumes from the frozen `cnt`. A phase is stretched, never shortened, so no runt pulses occur.
- **Reset (asserted at any time, including mid-period):** clears everything immediately.
  - `cnt`=0, `clk_out`=0, `tick_rise`=0, `tick_fall`=0, `pending`=0.
  - `active_div`=DEFAULT_DIV; the shadow register also resets to DEFAULT_DIV.

## Timing
- `clk_out` lags `cnt` by one cycle (registered compare).
- Reset release with `en`=1: the first rising clock edge sets `clk_out`=1 and `tick_rise`=1.
- Period is exactly N reference cycles with no skipped or duplicated edges.
- A ratio change takes effect on the first period starting after the boundary.
  - Latency from `div_load` to the new period is between 1 and N_old cycles.
  - The current period always completes at N_old.
- `pending` rises the cycle after `div_load` and falls the cycle after the applying boundary.
- `active_div` updates in the same cycle that `pending` falls.

## Configuration
- **`CLK_DIV_DUTY_PROG_EN` defined:**
  - The `duty_high` port exists.
  - H = `duty_high`, sampled together with `div_ratio` on `div_load` and applied at the same boundary.
  - H is clamped to 1..N-1, which guarantees both phases are at least 1 cycle.
  - H resets to ceil(DEFAULT_DIV/2).
- **Not defined:** no `duty_high` port; H = ceil(N/2), fixed ~50% duty.

## Test plan
- **Reset default:** release `rst` with `en`=1 and default parameters → `clk_out` repeats 4 high / 4 low. `tick_rise` fires every 8 cycles, and `tick_fall` 4 cycles after each `tick_rise`.
- **Mid-period load:** load 5 at `cnt`=2 → the current period completes at 8 cycles, then 3 high / 2 low. `pending` is 1 from the cycle after the load until the boundary, and `active_div` reads 5 afterwards.
- **Clamp and overwrite:** load 1, then load 3 one cycle later → next period is 3 cycles (2 high / 1 low). A lone load of 0 gives 1 high / 1 low.
- **Enable hold:** drop `en` for 5 cycles during a high phase → `clk_out` stays 1 and no strobes fire. Afterwards, the high phase lasts 4 + 5 cycles total and the low phase is unchanged at 4.
- **Reset mid-operation:** assert `rst` during a low phase with `pending`=1 → all outputs 0, `pending`=0 and `active_div`=8 asynchronously. The shadow value is discarded.
- **With `CLK_DIV_DUTY_PROG_EN`:** load N=10, H=3 → 3 high / 7 low. Load N=4, H=6 → clamped to 3 high / 1 low.

Source files
------------

// File: rtl/clk_div_prog_if.sv
// Control/status bundle for clk_div_prog. duty_high exists only when
// CLK_DIV_DUTY_PROG_EN is defined.
interface clk_div_prog_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             div_load;
    logic [CNT_W-1:0] div_ratio;
`ifdef CLK_DIV_DUTY_PROG_EN
    logic [CNT_W-1:0] duty_high;
`endif
    logic             clk_out;
    logic             tick_rise;
    logic             tick_fall;
    logic             pending;
    logic [CNT_W-1:0] active_div;

`ifdef CLK_DIV_DUTY_PROG_EN
    modport master (output en, div_load, div_ratio, duty_high,
                    input  clk_out, tick_rise, tick_fall, pending, active_div);
    modport slave  (input  en, div_load, div_ratio, duty_high,
                    output clk_out, tick_rise, tick_fall, pending, active_div);
`else
    modport master (output en, div_load, div_ratio,
                    input  clk_out, tick_rise, tick_fall, pending, active_div);
    modport slave  (input  en, div_load, div_ratio,
                    output clk_out, tick_rise, tick_fall, pending, active_div);
`endif
endinterface

// File: rtl/clk_div_prog.sv
// Programmable glitch-free integer clock divider with boundary-aligned ratio updates.
// Define CLK_DIV_DUTY_PROG_EN to add a programmable high-phase length (duty_high).
module clk_div_prog #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic         clk,
    input  logic         rst,
    clk_div_prog_if.slave bus
);
    localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             clk_out_q, clk_out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] load_n;
    logic             boundary;

    // Values 0 and 1 cannot produce a two-phase clock, so they become 2.
    assign load_n = (bus.div_ratio < TWO) ? TWO : bus.div_ratio;

`ifdef CLK_DIV_DUTY_PROG_EN
    localparam logic [CNT_W-1:0] DEF_H = CNT_W'((DEFAULT_DIV + 1) / 2);
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] shadow_h_q, shadow_h_d;
    logic [CNT_W-1:0] load_h;

    // Keep both phases at least one cycle long for the ratio being loaded.
    assign load_h   = (bus.duty_high == '0)    ? ONE :
                      (bus.duty_high >= load_n) ? (load_n - ONE) : bus.duty_high;
    assign high_len = high_q;
`else
    // ceil(N/2) without needing an extra carry bit.
    assign high_len = div_q[CNT_W-1:1] + {{(CNT_W-1){1'b0}}, div_q[0]};
`endif

    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        clk_out_d = clk_out_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        boundary  = (cnt_q == (div_q - ONE));
`ifdef CLK_DIV_DUTY_PROG_EN
        high_d     = high_q;
        shadow_h_d = shadow_h_q;
`endif
        if (bus.en) begin
            clk_out_d = (cnt_q < high_len);
            rise_d    = clk_out_d & ~clk_out_q;
            fall_d    = ~clk_out_d & clk_out_q;
            if (boundary) begin
                cnt_d = '0;
                if (pending_q) begin
                    div_d     = shadow_q;
                    pending_d = 1'b0;
`ifdef CLK_DIV_DUTY_PROG_EN
                    high_d    = shadow_h_q;
`endif
                end
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
        // A load in the boundary cycle lands after the swap above, so it waits a full period.
        if (bus.div_load) begin
            shadow_d  = load_n;
            pending_d = 1'b1;
`ifdef CLK_DIV_DUTY_PROG_EN
            shadow_h_d = load_h;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            div_q     <= DEF_N;
            shadow_q  <= DEF_N;
            pending_q <= 1'b0;
            clk_out_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
`ifdef CLK_DIV_DUTY_PROG_EN
            high_q     <= DEF_H;
            shadow_h_q <= DEF_H;
`endif
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            clk_out_q <= clk_out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
`ifdef CLK_DIV_DUTY_PROG_EN
            high_q     <= high_d;
            shadow_h_q <= shadow_h_d;
`endif
        end
    end

    assign bus.clk_out    = clk_out_q;
    assign bus.tick_rise  = rise_q;
    assign bus.tick_fall  = fall_q;
    assign bus.pending    = pending_q;
    assign bus.active_div = div_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: waveform-queue reference model checked
// every cycle, plus directed phase-length and reset expectations.
module tb_clk_div_prog;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    clk_div_prog_if #(.CNT_W(8)) bus ();

    clk_div_prog #(.CNT_W(8), .DEFAULT_DIV(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each period is a queue of expected clk_out levels,
    // H ones followed by N-H zeros; one element is consumed per enabled cycle.
    bit q[$];
    int m_n = 8, m_h = 4, m_sh_n = 8, m_sh_h = 4;
    bit m_pend = 0, m_out = 0, m_rise = 0, m_fall = 0;
    int run_len = 0, last_high = 0, last_low = 0;
    bit prev_out = 0;

    function automatic int clamp_n(input int r);
        return (r < 2) ? 2 : r;
    endfunction

    function automatic int pick_h(input int n, input int d);
`ifdef CLK_DIV_DUTY_PROG_EN
        if (d < 1) return 1;
        if (d > n - 1) return n - 1;
        return d;
`else
        return (n + 1) / 2;
`endif
    endfunction

    always @(posedge clk) begin
        bit nxt;
        int dreq;
        if (rst) begin
            q.delete();
            m_n = 8; m_h = 4; m_sh_n = 8; m_sh_h = 4;
            m_pend = 0; m_out = 0; m_rise = 0; m_fall = 0;
        end else begin
            m_rise = 0;
            m_fall = 0;
            if (bus.en) begin
                if (q.size() == 0)
                    for (int i = 0; i < m_n; i++) q.push_back(i < m_h);
                nxt    = q.pop_front();
                m_rise = nxt & !m_out;
                m_fall = !nxt & m_out;
                m_out  = nxt;
                if (q.size() == 0 && m_pend) begin
                    m_n = m_sh_n;
                    m_h = m_sh_h;
                    m_pend = 0;
                end
            end
            if (bus.div_load) begin
`ifdef CLK_DIV_DUTY_PROG_EN
                dreq = int'(bus.duty_high);
`else
                dreq = 0;
`endif
                m_sh_n = clamp_n(int'(bus.div_ratio));
                m_sh_h = pick_h(m_sh_n, dreq);
                m_pend = 1;
            end
        end
        #2;
        check("clk_out",    int'(bus.clk_out),    int'(m_out));
        check("tick_rise",  int'(bus.tick_rise),  int'(m_rise));
        check("tick_fall",  int'(bus.tick_fall),  int'(m_fall));
        check("pending",    int'(bus.pending),    int'(m_pend));
        check("active_div", int'(bus.active_div), m_n);
        // Phase-length tracker for the directed expectations.
        if (rst) begin
            run_len = 0;
            prev_out = 0;
        end else if (bus.clk_out == prev_out) begin
            run_len++;
        end else begin
            if (prev_out) last_high = run_len;
            else last_low = run_len;
            run_len = 1;
            prev_out = bus.clk_out;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rise();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.tick_rise && k < 60);
        if (!bus.tick_rise) check("wait_rise_timeout", 0, 1);
    endtask

    task automatic wait_fall();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.tick_fall && k < 60);
        if (!bus.tick_fall) check("wait_fall_timeout", 0, 1);
    endtask

    task automatic load(input int n, input int h);
        bus.div_load  = 1'b1;
        bus.div_ratio = 8'(n);
`ifdef CLK_DIV_DUTY_PROG_EN
        bus.duty_high = 8'(h);
`endif
        @(negedge clk);
        bus.div_load = 1'b0;
    endtask

    initial begin
        int unused_h;
        unused_h = 0;
        bus.en = 1'b1;
        bus.div_load = 1'b0;
        bus.div_ratio = '0;
`ifdef CLK_DIV_DUTY_PROG_EN
        bus.duty_high = '0;
`endif
        cycles(3);
        check("rst_clk_out", int'(bus.clk_out), 0);
        check("rst_active_div", int'(bus.active_div), 8);
        check("rst_pending", int'(bus.pending), 0);
        rst = 1'b0;
        @(negedge clk);
        check("first_edge_clk_out", int'(bus.clk_out), 1);
        check("first_edge_rise", int'(bus.tick_rise), 1);

        // Default divide-by-8, 4 high / 4 low.
        cycles(24);
        check("def_high", last_high, 4);
        check("def_low", last_low, 4);

        // Mid-period load of 5 at cnt=2.
        wait_rise();
        @(negedge clk);
        load(5, unused_h);
        check("mid_pending", int'(bus.pending), 1);
        check("mid_active_old", int'(bus.active_div), 8);
        cycles(25);
        check("mid_high", last_high, 3);
        check("mid_low", last_low, 2);
        check("mid_active_new", int'(bus.active_div), 5);

        // Clamp plus overwrite: 1 then 3, last wins.
        load(1, unused_h);
        load(3, unused_h);
        cycles(15);
        check("ovr_high", last_high, 2);
        check("ovr_low", last_low, 1);
        check("ovr_active", int'(bus.active_div), 3);

        // Lone load of 0 clamps to 2.
        load(0, unused_h);
        cycles(10);
        check("clamp_high", last_high, 1);
        check("clamp_low", last_low, 1);
        check("clamp_active", int'(bus.active_div), 2);

        // Back to 8, then hold enable low for 5 cycles in the high phase.
        load(8, 4);
        cycles(24);
        wait_rise();
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_clk_out", int'(bus.clk_out), 1);
            check("hold_rise", int'(bus.tick_rise), 0);
            check("hold_fall", int'(bus.tick_fall), 0);
        end
        bus.en = 1'b1;
        wait_fall();
        check("hold_high", last_high, 9);
        wait_rise();
        check("hold_low", last_low, 4);

        // Asynchronous reset in a low phase with a pending load.
        wait_fall();
        load(5, unused_h);
        check("rstmid_pending", int'(bus.pending), 1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_clk_out", int'(bus.clk_out), 0);
        check("rstmid_pending0", int'(bus.pending), 0);
        check("rstmid_active", int'(bus.active_div), 8);
        check("rstmid_rise", int'(bus.tick_rise), 0);
        check("rstmid_fall", int'(bus.tick_fall), 0);
        @(negedge clk);
        rst = 1'b0;
        cycles(26);
        check("post_rst_high", last_high, 4);
        check("post_rst_low", last_low, 4);
        check("post_rst_active", int'(bus.active_div), 8);

`ifdef CLK_DIV_DUTY_PROG_EN
        load(10, 3);
        cycles(35);
        check("duty_high_3", last_high, 3);
        check("duty_low_7", last_low, 7);
        load(4, 6);
        cycles(20);
        check("duty_clamp_high", last_high, 3);
        check("duty_clamp_low", last_low, 1);
`endif

        cycles(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
